// File: rtl/sm_uart_tx_port_if.sv
// CPU data-bus bundle for the memory-mapped UART transmitter.
// The CPU side drives address/strobe/data; the peripheral returns read data.
interface sm_uart_tx_port_if;
  logic [31:0] busAddr;
  logic        busWriteEnable;
  logic [31:0] busWData;
  logic [31:0] busRData;

  modport master (output busAddr, output busWriteEnable, output busWData, input busRData);
  modport slave  (input busAddr, input busWriteEnable, input busWData, output busRData);
endinterface

// File: rtl/sm_uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter: DATA writes fill a small FIFO that is
// serialized LSB first on uartTx; STATUS reports busy/full/idle/overflow.
module sm_uart_tx_port #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_8000,
  parameter int          BAUD_DIV   = 16,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  sm_uart_tx_port_if.slave   bus,
  output logic               uartTx
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(BAUD_DIV);

  localparam logic [31:0]       STATUS_ADDR = BASE_ADDR + 32'd4;
  localparam logic [CNT_W-1:0]  FULL_COUNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [BAUD_W-1:0] BAUD_LAST   = BAUD_W'(BAUD_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shift_reg;
  logic              tx_line;

  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              ovf;

  logic data_sel;
  logic status_sel;
  logic push_req;
  logic push;
  logic pop;
  logic full;
  logic empty;
  logic busy;
  logic idle;
  logic bit_end;
  logic [7:0] head;
  logic unused_wdata;

  assign data_sel   = (bus.busAddr == BASE_ADDR);
  assign status_sel = (bus.busAddr == STATUS_ADDR);
  assign full       = (count == FULL_COUNT);
  assign empty      = (count == '0);
  assign busy       = (state != IDLE);
  assign idle       = empty && !busy;
  assign bit_end    = (baud_cnt == BAUD_LAST);
  assign head       = fifo_mem[rd_ptr];

  // Fullness is judged before any same-cycle pop, so a full FIFO always drops.
  assign push_req = bus.busWriteEnable && data_sel;
  assign push     = push_req && !full;
  assign pop      = !empty && ((state == IDLE) || (state == STOP && bit_end));

  assign unused_wdata = &{1'b0, bus.busWData[31:8]};

  assign bus.busRData = status_sel ? {28'b0, ovf, idle, full, busy} : 32'b0;
  assign uartTx       = tx_line;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= bus.busWData[7:0];
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req && full) begin
        ovf <= 1'b1;
      end else if (bus.busWriteEnable && status_sel && bus.busWData[0]) begin
        ovf <= 1'b0;
      end
    end
  end

  // Frame sequencer; uartTx is registered and follows the state it enters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tx_line   <= 1'b1;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx_line <= 1'b1;
          if (pop) begin
            shift_reg <= head;
            baud_cnt  <= '0;
            tx_line   <= 1'b0;
            state     <= START;
          end
        end
        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx_line  <= shift_reg[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt  <= '0;
            shift_reg <= shift_reg >> 1;
            if (bit_idx == 3'd7) begin
              tx_line <= 1'b1;
              state   <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx_line <= shift_reg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (pop) begin
              shift_reg <= head;
              tx_line   <= 1'b0;
              state     <= START;
            end else begin
              tx_line <= 1'b1;
              state   <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          tx_line <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sm_uart_tx_port.sv
// Self-checking bench for sm_uart_tx_port: a line decoder pops expected bytes
// from a scoreboard queue, while directed steps check timing and STATUS.
module tb_sm_uart_tx_port;

  localparam logic [31:0] BASE  = 32'h0000_8000;
  localparam logic [31:0] STAT  = BASE + 32'd4;
  localparam int          B     = 4;
  localparam int          DEPTH = 4;
  localparam int          FRAME = 10 * B;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        uartTx;
  logic [31:0] rdata;
  logic [7:0]  exp_q [$];
  logic        mon_active = 1'b0;
  int          mon_cyc = 0;
  logic [7:0]  mon_byte;
  logic [7:0]  sb;
  logic        exp_bit;
  int          tests_run = 0;
  int          tests_failed = 0;

  sm_uart_tx_port_if bus ();

  sm_uart_tx_port #(
    .BASE_ADDR (BASE),
    .BAUD_DIV  (B),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus.slave),
    .uartTx(uartTx)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  // One bus write, sampled on the next rising edge; returns just after that edge.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.busAddr        = addr;
    bus.busWData       = data;
    bus.busWriteEnable = 1'b1;
    @(posedge clk);
    #1;
    bus.busWriteEnable = 1'b0;
  endtask

  task automatic readBus(input logic [31:0] addr, output logic [31:0] data);
    bus.busWriteEnable = 1'b0;
    bus.busAddr        = addr;
    #1;
    data = bus.busRData;
  endtask

  task automatic sendByte(input logic [7:0] b, input bit expect_tx);
    applyStimulus(BASE, {24'hDEADBE, b});
    if (expect_tx) exp_q.push_back(b);
  endtask

  task automatic waitIdle(input int limit);
    logic [31:0] st;
    bit done;
    done = 1'b0;
    for (int i = 0; i < limit && !done; i++) begin
      @(negedge clk);
      readBus(STAT, st);
      if (st[2]) done = 1'b1;
    end
    checkOutput("wait_idle_timeout", {31'b0, done}, 32'd1);
  endtask

  // Line decoder: samples mid-bit, aborts on reset.
  always @(negedge clk) begin
    if (rst) begin
      mon_active = 1'b0;
    end else begin
      if (!mon_active && uartTx == 1'b0) begin
        mon_active = 1'b1;
        mon_cyc    = 0;
      end else if (mon_active) begin
        mon_cyc++;
      end
      if (mon_active) begin
        if (mon_cyc == B / 2) begin
          checkOutput("rx_start_bit", {31'b0, uartTx}, 32'd0);
        end else if (mon_cyc == 9 * B + B / 2) begin
          checkOutput("rx_stop_bit", {31'b0, uartTx}, 32'd1);
          if (exp_q.size() == 0) begin
            checkOutput("rx_unexpected_frame", {24'b0, mon_byte}, 32'hFFFF_FFFF);
          end else begin
            checkOutput("rx_byte", {24'b0, mon_byte}, {24'b0, exp_q.pop_front()});
          end
          mon_active = 1'b0;
        end else if (mon_cyc > B && mon_cyc < 9 * B && (mon_cyc % B) == B / 2) begin
          mon_byte[(mon_cyc / B) - 1] = uartTx;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation watchdog expired");
  end

  initial begin
    bus.busAddr        = 32'h0;
    bus.busWData       = 32'h0;
    bus.busWriteEnable = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    checkOutput("reset_uart_tx", {31'b0, uartTx}, 32'd1);
    readBus(STAT, rdata);
    checkOutput("reset_status", rdata, 32'h4);
    readBus(BASE, rdata);
    checkOutput("data_read_zero", rdata, 32'h0);

    // Single byte: exact waveform, cycle by cycle
    sb = 8'hA5;
    sendByte(sb, 1'b1);
    @(negedge clk);
    checkOutput("pre_start_high", {31'b0, uartTx}, 32'd1);
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      if (c < B)          exp_bit = 1'b0;
      else if (c < 9 * B) exp_bit = sb[(c - B) / B];
      else                exp_bit = 1'b1;
      checkOutput($sformatf("a5_wave_c%0d", c), {31'b0, uartTx}, {31'b0, exp_bit});
    end
    readBus(STAT, rdata);
    checkOutput("a5_last_stop_busy", rdata, 32'h1);
    @(negedge clk);
    readBus(STAT, rdata);
    checkOutput("a5_status_idle", rdata, 32'h4);

    // Back-to-back: three contiguous frames, busy never drops
    sendByte(8'h00, 1'b1);
    sendByte(8'hFF, 1'b1);
    sendByte(8'h55, 1'b1);
    for (int c = 2; c <= 3 * FRAME; c++) begin
      @(negedge clk);
      readBus(STAT, rdata);
      checkOutput($sformatf("b2b_busy_c%0d", c), {30'b0, rdata[2], rdata[0]}, 32'h1);
    end
    @(negedge clk);
    readBus(STAT, rdata);
    checkOutput("b2b_status_idle", rdata, 32'h4);

    // Overflow: FIFO_DEPTH+1 bytes accepted, the next one dropped
    for (int i = 0; i < DEPTH + 2; i++) begin
      sendByte(8'h30 + 8'(i), i < DEPTH + 1);
    end
    @(negedge clk);
    readBus(STAT, rdata);
    checkOutput("ovf_status_full", rdata, 32'hB);
    waitIdle((DEPTH + 2) * FRAME);
    readBus(STAT, rdata);
    checkOutput("ovf_sticky", rdata, 32'hC);

    // Decode: off-window writes do nothing, including bit0 at BASE+8
    applyStimulus(BASE + 32'd8, 32'h0000_0177);
    applyStimulus(BASE - 32'd4, 32'h0000_0055);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      checkOutput("decode_line_high", {31'b0, uartTx}, 32'd1);
      readBus(STAT, rdata);
      checkOutput("decode_status", rdata, 32'hC);
    end
    readBus(BASE + 32'd8, rdata);
    checkOutput("decode_read_plus8", rdata, 32'h0);
    readBus(BASE - 32'd4, rdata);
    checkOutput("decode_read_minus4", rdata, 32'h0);

    // Overflow clear
    applyStimulus(STAT, 32'hFFFF_FFF1);
    @(negedge clk);
    readBus(STAT, rdata);
    checkOutput("ovf_cleared", rdata, 32'h4);

    // Reset mid-frame during data bit 3 with two bytes queued
    sendByte(8'h11, 1'b0);
    sendByte(8'h22, 1'b0);
    sendByte(8'h33, 1'b0);
    repeat (15) @(negedge clk);
    @(negedge clk);
    rst                = 1'b1;
    bus.busAddr        = BASE;
    bus.busWData       = 32'h0000_0099;
    bus.busWriteEnable = 1'b1;
    @(negedge clk);
    checkOutput("rst_line_high", {31'b0, uartTx}, 32'd1);
    readBus(STAT, rdata);
    checkOutput("rst_status", rdata, 32'h4);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checkOutput("post_rst_line_high", {31'b0, uartTx}, 32'd1);
      readBus(STAT, rdata);
      checkOutput("post_rst_status", rdata, 32'h4);
    end
    sendByte(8'h3C, 1'b1);
    waitIdle(2 * FRAME);

    repeat (4) @(negedge clk);
    checkOutput("frames_pending", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
